// File: rtl/vmx_dma_cmd_sequencer.sv
// VMX command sequencer: pops ISA commands, programs the DMA engine, and for LOADs
// drains returned DMA words into the local vector buffer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command; pops ISA FIFO when not empty
// FETCH     | ISA word valid this cycle, latch into command register
// DECODE    | classify opcode; NOP/zero-length retire here
// ISSUE     | DMA_CTRL start pulse high; arm timeout, load drain counters
// WAIT_DONE | STORE in progress; wait for DMA done level
// DRAIN     | LOAD in progress; move DMA FIFO words into the vector buffer
// ERROR     | terminal fault; only reset leaves
module vmx_dma_cmd_sequencer #(
   parameter int LEN_W   = 12,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [31:0]       ISA_FIFO_DATA,
   input  logic              ISA_FIFO_EMPTY,
   output logic              ISA_FIFO_RDEN,
   input  logic [31:0]       DMA_FLAG,
   output logic [31:0]       DMA_CTRL,
   input  logic [31:0]       DMA_FIFO_DATA,
   input  logic              DMA_FIFO_EMPTY,
   output logic              DMA_FIFO_RDEN,
   output logic              BUF_WE,
   output logic [ADDR_W-1:0] BUF_ADDR,
   output logic [31:0]       BUF_WDATA,
   output logic              BUSY,
   output logic              ERR,
   output logic [1:0]        ERR_CODE,
   output logic [15:0]       CMD_CNT
);

   localparam int               TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
   localparam logic [3:0]       OP_NOP   = 4'h0;
   localparam logic [3:0]       OP_LOAD  = 4'h1;
   localparam logic [3:0]       OP_STORE = 4'h2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_ISSUE,
      S_WAIT_DONE,
      S_DRAIN,
      S_ERROR
   } state_t;

   state_t            state;
   logic              live;
   logic [31:0]       cmd_q;
   logic [LEN_W-1:0]  rem;
   logic              pop_q;
   logic [ADDR_W-1:0] wr_ptr;
   logic [TMR_W-1:0]  tmr;
   logic [31:0]       dma_ctrl_q;
   logic              err_q;
   logic [1:0]        err_code_q;
   logic [15:0]       cmd_cnt_q;

   logic [3:0]        opcode;
   logic [LEN_W-1:0]  cmd_len;
   logic [ADDR_W-1:0] cmd_addr;
   logic              isa_rden;
   logic              dma_rden;
   logic              flag_err;
   logic              flag_done;
   logic              tmr_hit;
   logic              drain_fin;
   logic              unused_flag_bits;

   assign opcode    = cmd_q[31:28];
   assign cmd_len   = cmd_q[16 +: LEN_W];
   assign cmd_addr  = cmd_q[ADDR_W-1:0];
   assign flag_err  = DMA_FLAG[2];
   assign flag_done = DMA_FLAG[1];
   assign tmr_hit   = (tmr == '0);
   assign drain_fin = (rem == '0) && !pop_q;
   assign unused_flag_bits = ^{DMA_FLAG[31:3], DMA_FLAG[0]};

   // live holds pops off while reset is asserted and for the first cycle after it
   assign isa_rden = live && (state == S_IDLE) && !ISA_FIFO_EMPTY;

   // at most one word in flight, so remaining minus in-flight is rem - pop_q;
   // no pop on a cycle that leaves DRAIN for ERROR
   assign dma_rden = (state == S_DRAIN) && !DMA_FIFO_EMPTY &&
                     (rem > {{(LEN_W-1){1'b0}}, pop_q}) && !flag_err && !tmr_hit;

   assign ISA_FIFO_RDEN = isa_rden;
   assign DMA_FIFO_RDEN = dma_rden;
   assign DMA_CTRL      = dma_ctrl_q;
   assign BUF_WE        = pop_q;
   assign BUF_ADDR      = wr_ptr;
   assign BUF_WDATA     = pop_q ? DMA_FIFO_DATA : '0;
   // the pop cycle already commits the sequencer, so it counts as busy
   assign BUSY          = (state != S_IDLE) || isa_rden;
   assign ERR           = err_q;
   assign ERR_CODE      = err_code_q;
   assign CMD_CNT       = cmd_cnt_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         live       <= 1'b0;
         cmd_q      <= '0;
         rem        <= '0;
         pop_q      <= 1'b0;
         wr_ptr     <= '0;
         tmr        <= '0;
         dma_ctrl_q <= '0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         cmd_cnt_q  <= '0;
      end else begin
         live  <= 1'b1;
         pop_q <= dma_rden;
         if (pop_q) begin
            rem    <= rem - 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (isa_rden) state <= S_FETCH;
            end
            S_FETCH: begin
               cmd_q <= ISA_FIFO_DATA;
               state <= S_DECODE;
            end
            S_DECODE: begin
               if (opcode == OP_NOP) begin
                  cmd_cnt_q <= cmd_cnt_q + 1'b1;
                  state     <= S_IDLE;
               end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                  if (cmd_len == '0) begin
                     cmd_cnt_q <= cmd_cnt_q + 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     dma_ctrl_q <= {1'b1, opcode[2:0], cmd_q[27:0]};
                     state      <= S_ISSUE;
                  end
               end else begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd1;
                  state      <= S_ERROR;
               end
            end
            S_ISSUE: begin
               dma_ctrl_q[31] <= 1'b0;
               tmr            <= TMR_LOAD;
               rem            <= cmd_len;
               wr_ptr         <= cmd_addr;
               state          <= (opcode == OP_LOAD) ? S_DRAIN : S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (flag_err) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd2;
                  state      <= S_ERROR;
               end else if (flag_done) begin
                  cmd_cnt_q <= cmd_cnt_q + 1'b1;
                  state     <= S_IDLE;
               end else if (tmr_hit) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd3;
                  state      <= S_ERROR;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_DRAIN: begin
               if (flag_err) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd2;
                  state      <= S_ERROR;
               end else if (drain_fin) begin
                  cmd_cnt_q <= cmd_cnt_q + 1'b1;
                  state     <= S_IDLE;
               end else if (tmr_hit) begin
                  err_q      <= 1'b1;
                  err_code_q <= 2'd3;
                  state      <= S_ERROR;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            S_ERROR: begin
               state <= S_ERROR;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vmx_dma_cmd_sequencer.sv
// Scoreboard bench for vmx_dma_cmd_sequencer: FIFO models feed the DUT, expected
// buffer writes and DMA starts are queued at stimulus time and popped as they appear.
module tb_vmx_dma_cmd_sequencer;

   localparam int TO = 100;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [31:0] ISA_FIFO_DATA = '0;
   logic        ISA_FIFO_EMPTY = 1'b1;
   logic        ISA_FIFO_RDEN;
   logic [31:0] DMA_FLAG = '0;
   logic [31:0] DMA_CTRL;
   logic [31:0] DMA_FIFO_DATA = '0;
   logic        DMA_FIFO_EMPTY = 1'b1;
   logic        DMA_FIFO_RDEN;
   logic        BUF_WE;
   logic [15:0] BUF_ADDR;
   logic [31:0] BUF_WDATA;
   logic        BUSY;
   logic        ERR;
   logic [1:0]  ERR_CODE;
   logic [15:0] CMD_CNT;

   vmx_dma_cmd_sequencer #(.LEN_W(12), .ADDR_W(16), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .ISA_FIFO_DATA(ISA_FIFO_DATA), .ISA_FIFO_EMPTY(ISA_FIFO_EMPTY), .ISA_FIFO_RDEN(ISA_FIFO_RDEN),
      .DMA_FLAG(DMA_FLAG), .DMA_CTRL(DMA_CTRL),
      .DMA_FIFO_DATA(DMA_FIFO_DATA), .DMA_FIFO_EMPTY(DMA_FIFO_EMPTY), .DMA_FIFO_RDEN(DMA_FIFO_RDEN),
      .BUF_WE(BUF_WE), .BUF_ADDR(BUF_ADDR), .BUF_WDATA(BUF_WDATA),
      .BUSY(BUSY), .ERR(ERR), .ERR_CODE(ERR_CODE), .CMD_CNT(CMD_CNT)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int n_isa_pop = 0;
   int n_dma_pop = 0;
   int n_busy = 0;
   int n_start = 0;

   logic [31:0] isa_q[$];
   logic [31:0] dq[$];
   logic [47:0] exp_wr[$];
   logic [31:0] exp_ctrl[$];
   logic        isa_take = 1'b0;
   logic        dma_take = 1'b0;
   logic        tog = 1'b0;
   logic        dma_blk = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
      exp_wr.push_back({a, d});
   endtask

   // monitor: sample away from the active edge, consume scoreboard entries
   always @(negedge CLK) begin
      logic [47:0] e;
      isa_take = ISA_FIFO_RDEN;
      dma_take = DMA_FIFO_RDEN;
      if (ISA_FIFO_RDEN) begin
         n_isa_pop++;
         chk("isa_rden_while_empty", 32'(ISA_FIFO_EMPTY), 0);
      end
      if (DMA_FIFO_RDEN) begin
         n_dma_pop++;
         chk("dma_rden_while_empty", 32'(DMA_FIFO_EMPTY), 0);
      end
      if (BUSY) n_busy++;
      if (DMA_CTRL[31]) begin
         n_start++;
         chk("ctrl_expected", 32'(exp_ctrl.size() != 0), 1);
         if (exp_ctrl.size() != 0) chk("ctrl_start", DMA_CTRL, exp_ctrl.pop_front());
      end
      if (BUF_WE) begin
         chk("wr_expected", 32'(exp_wr.size() != 0), 1);
         if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(BUF_ADDR), 32'(e[47:32]));
            chk("wr_data", BUF_WDATA, e[31:0]);
         end
      end
   end

   // FIFO models: pops sampled at negedge take effect just after the next posedge
   always @(posedge CLK) begin
      #1;
      if (isa_take && isa_q.size() > 0) ISA_FIFO_DATA = isa_q.pop_front();
      if (dma_take && dq.size() > 0) DMA_FIFO_DATA = dq.pop_front();
      dma_blk = tog ? !dma_blk : 1'b0;
      ISA_FIFO_EMPTY = (isa_q.size() == 0);
      DMA_FIFO_EMPTY = (dq.size() == 0) || dma_blk;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      DMA_FLAG = '0;
      tog = 1'b0;
      isa_q.delete();
      dq.delete();
      exp_wr.delete();
      exp_ctrl.delete();
      tick(3);
      RST_N = 1'b1;
      tick(1);
   endtask

   task automatic wait_cmd(input string tag);
      int k;
      k = 0;
      while (!BUSY && k < 50) begin tick(1); k++; end
      while (BUSY && k < 400) begin tick(1); k++; end
      chk(tag, 32'(BUSY), 0);
      tick(1);
   endtask

   task automatic wait_start(input string tag);
      int k;
      k = 0;
      while (!DMA_CTRL[31] && k < 30) begin tick(1); k++; end
      chk(tag, 32'(DMA_CTRL[31]), 1);
   endtask

   initial begin
      int b_busy, b_isa, b_dma, b_start, k;

      // reset values
      RST_N = 1'b0;
      tick(2);
      chk("rst_ctrl", DMA_CTRL, 0);
      chk("rst_outs", 32'({ERR, ERR_CODE, BUSY, BUF_WE, ISA_FIFO_RDEN, DMA_FIFO_RDEN, BUF_ADDR}), 0);
      chk("rst_cnt_wdata", BUF_WDATA | 32'(CMD_CNT), 0);
      do_reset();

      // 1: NOP
      b_busy = n_busy; b_isa = n_isa_pop; b_start = n_start;
      isa_q.push_back(32'h0000_0000);
      wait_cmd("nop_idle");
      chk("nop_busy_cycles", 32'(n_busy - b_busy), 3);
      chk("nop_isa_pops", 32'(n_isa_pop - b_isa), 1);
      chk("nop_starts", 32'(n_start - b_start), 0);
      chk("nop_cmd_cnt", 32'(CMD_CNT), 1);

      // 2: LOAD len 4, back-to-back data
      b_dma = n_dma_pop; b_start = n_start;
      for (int i = 0; i < 4; i++) begin
         dq.push_back(32'hA0 + 32'(i));
         push_wr(16'h0010 + 16'(i), 32'hA0 + 32'(i));
      end
      exp_ctrl.push_back(32'h9004_0010);
      isa_q.push_back(32'h1004_0010);
      wait_cmd("load4_idle");
      chk("load4_pops", 32'(n_dma_pop - b_dma), 4);
      chk("load4_starts", 32'(n_start - b_start), 1);
      chk("load4_wr_left", 32'(exp_wr.size()), 0);
      chk("load4_ctrl_hold", DMA_CTRL, 32'h1004_0010);
      chk("load4_cmd_cnt", 32'(CMD_CNT), 2);

      // 3: LOAD len 3 with toggling DMA empty, 6 words offered
      b_dma = n_dma_pop;
      tog = 1'b1;
      for (int i = 0; i < 6; i++) dq.push_back(32'hB0 + 32'(i));
      for (int i = 0; i < 3; i++) push_wr(16'h0200 + 16'(i), 32'hB0 + 32'(i));
      exp_ctrl.push_back(32'h9003_0200);
      isa_q.push_back(32'h1003_0200);
      wait_cmd("load3_idle");
      chk("load3_pops", 32'(n_dma_pop - b_dma), 3);
      chk("load3_left_in_fifo", 32'(dq.size()), 3);
      chk("load3_wr_left", 32'(exp_wr.size()), 0);
      chk("load3_cmd_cnt", 32'(CMD_CNT), 3);
      tog = 1'b0;
      dq.delete();
      tick(2);

      // 4: STORE, done 20 cycles after start
      exp_ctrl.push_back(32'hA008_0100);
      isa_q.push_back(32'h2008_0100);
      wait_start("store_start_seen");
      tick(20);
      chk("store_busy_before_done", 32'(BUSY), 1);
      DMA_FLAG = 32'h2;
      tick(1);
      chk("store_idle_after_done", 32'(BUSY), 0);
      chk("store_cmd_cnt", 32'(CMD_CNT), 4);
      DMA_FLAG = '0;
      tick(2);

      // 5: illegal opcode, following command must stay queued
      b_isa = n_isa_pop; b_start = n_start;
      isa_q.push_back(32'h7000_0000);
      isa_q.push_back(32'h0000_0000);
      tick(12);
      chk("illegal_err", 32'({ERR, ERR_CODE}), 32'h5);
      chk("illegal_busy", 32'(BUSY), 1);
      chk("illegal_no_start", 32'(n_start - b_start), 0);
      chk("illegal_isa_pops", 32'(n_isa_pop - b_isa), 1);
      chk("illegal_left_queued", 32'(isa_q.size()), 1);
      chk("illegal_cmd_cnt", 32'(CMD_CNT), 4);

      // 6a: STORE timeout
      do_reset();
      exp_ctrl.push_back(32'hA001_0000);
      isa_q.push_back(32'h2001_0000);
      wait_start("to_start_seen");
      k = 0;
      while (!ERR && k < 300) begin tick(1); k++; end
      chk("to_cycles", 32'(k), TO + 1);
      chk("to_code", 32'(ERR_CODE), 3);
      chk("to_cmd_cnt", 32'(CMD_CNT), 0);

      // 6b: done and error together -> DMA error wins
      do_reset();
      exp_ctrl.push_back(32'hA001_0000);
      isa_q.push_back(32'h2001_0000);
      wait_start("derr_start_seen");
      tick(5);
      DMA_FLAG = 32'h6;
      tick(1);
      chk("derr_err", 32'({ERR, ERR_CODE}), 32'h6);
      chk("derr_cmd_cnt", 32'(CMD_CNT), 0);
      DMA_FLAG = '0;

      // 6c: async reset mid-DRAIN
      do_reset();
      b_dma = n_dma_pop;
      dq.push_back(32'hC0);
      dq.push_back(32'hC1);
      push_wr(16'h0040, 32'hC0);
      push_wr(16'h0041, 32'hC1);
      exp_ctrl.push_back(32'h9008_0040);
      isa_q.push_back(32'h1008_0040);
      k = 0;
      while ((n_dma_pop - b_dma) < 2 && k < 50) begin tick(1); k++; end
      tick(3);
      chk("drain_pre_addr", 32'(BUF_ADDR), 32'h42);
      chk("drain_pre_busy", 32'(BUSY), 1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_ctrl", DMA_CTRL, 0);
      chk("async_rst_outs", 32'({ERR, ERR_CODE, BUSY, BUF_WE, ISA_FIFO_RDEN, DMA_FIFO_RDEN, BUF_ADDR}), 0);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
